spi_arb: RTL and testbench

- Shares one SPI_mnrch master between two requesters.
- Requester 0 is the inertial sequencer (pitch/AZ reads). Requester 1 is a generic register-access port (sensor reconfiguration, diagnostics).
- Performs round-robin arbitration and owns the wrt/done handshake to the SPI master.
- Enforces an inter-frame gap and a watchdog timeout.

---
 rtl/spi_arb_pkg.sv | 31 +++
 rtl/spi_arb_rr_arb2.sv | 41 ++++
 rtl/spi_arb.sv | 143 ++++++++++++++
 tb/tb_spi_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared types and constants for the two-requester SPI arbiter.
//               Contains the FSM state type, the requester indices and the
//               default and fast-simulation gap/timeout lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int REQ_INERT = 0;   // inertial sequencer (pitch/AZ reads)
    localparam int REQ_AUX   = 1;   // generic register-access port
    localparam int NUM_REQ   = 2;

    // Silicon defaults
    localparam int GAP_CYC_DEF  = 32;
    localparam int TMO_CYC_DEF  = 4096;

    // Short values for fast simulation runs
    localparam int GAP_CYC_FAST = 4;
    localparam int TMO_CYC_FAST = 64;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin picker.
//               req  [1:0] : active requests
//               last       : index of the requester served most recently
//               pick [1:0] : one-hot winner (zero when nothing requests)
//               idx        : winner index (0 when nothing requests)
//               A sole requester always wins; on a tie the requester that
//               was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import spi_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] pick,
    output logic               idx
);

    logic w_tie;

    assign w_tie = req[0] & req[1];

    always_comb begin
        idx  = 1'b0;
        pick = '0;
        if (w_tie) begin
            idx = ~last;
        end else begin
            // Lone request from requester 1 selects index 1, anything else 0
            idx = req[1];
        end
        if (req != '0) begin
            pick = idx ? 2'b10 : 2'b01;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb
// Description : Shares one SPI master between two requesters using
//               round-robin arbitration. Owns the wrt/done handshake to the
//               master, inserts a fixed idle gap after each frame and aborts
//               frames that exceed a watchdog limit.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req0/1, wt_data0/1  - per-requester level request + command
//               gnt, done, err      - one-hot grant, done and timeout pulses
//               rd_data             - last captured SPI read word
//               busy                - high whenever the arbiter is not IDLE
//               spi_wrt, spi_cmd    - strobe and command to the SPI master
//               spi_done, spi_rd_data - completion and read data from master
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [15:0]         wt_data0,
    input  logic                req1,
    input  logic [15:0]         wt_data1,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [NUM_REQ-1:0]  done,
    output logic [NUM_REQ-1:0]  err,
    output logic [15:0]         rd_data,
    output logic                busy,
    output logic                spi_wrt,
    output logic [15:0]         spi_cmd,
    input  logic                spi_done,
    input  logic [15:0]         spi_rd_data
);

    // One counter serves both the BUSY watchdog and the GAP length; the two
    // states never overlap.
    localparam int CNT_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    arb_state_t         r_state;
    logic               r_idx;     // index of the current winner
    logic               r_last;    // index of the requester served last
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_pick_idx;

    assign w_req = {req1, req0};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last),
        .pick (w_pick),
        .idx  (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 1'b0;
            r_last  <= 1'b1;       // requester 0 wins the first tie
            r_cnt   <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            rd_data <= '0;
            busy    <= 1'b0;
            spi_wrt <= 1'b0;
            spi_cmd <= '0;
        end else begin
            // Pulse outputs default low every cycle
            done    <= '0;
            err     <= '0;
            spi_wrt <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_pick != '0) begin
                        r_idx   <= w_pick_idx;
                        gnt     <= w_pick;
                        spi_cmd <= (w_pick_idx == 1'(REQ_AUX)) ? wt_data1 : wt_data0;
                        spi_wrt <= 1'b1;   // high for the single ISSUE cycle
                        busy    <= 1'b1;
                        r_state <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= BUSY;
                end

                BUSY: begin
                    // A completion on the watchdog's last cycle still counts
                    // as a completion, so spi_done is checked first.
                    if (spi_done) begin
                        rd_data <= spi_rd_data;
                        done    <= gnt;
                        r_last  <= r_idx;
                        r_cnt   <= '0;
                        r_state <= GAP;
                    end else if (r_cnt == c_tmo_last) begin
                        err     <= gnt;
                        r_last  <= r_idx;
                        r_cnt   <= '0;
                        r_state <= GAP;
                    end else begin
                        r_cnt   <= r_cnt + c_one;
                    end
                end

                GAP: begin
                    // Grant stays up through the done/err cycle (first GAP
                    // cycle) and drops from the second one onwards.
                    gnt <= '0;
                    if (r_cnt == c_gap_last) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + c_one;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : spi_arb
`default_nettype wire

// File: tb/tb_spi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arb
// Description : Self-checking bench for spi_arb. Frames are predicted at the
//               transaction level: who wins (round-robin rule), which command
//               goes out, when done/err appear and what rd_data holds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_arb;
    import spi_arb_pkg::*;

    localparam int GAP_CYC = GAP_CYC_FAST;
    localparam int TMO_CYC = TMO_CYC_FAST;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] wt_data0 = '0;
    logic [15:0] wt_data1 = '0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] rd_data;
    logic        busy;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd_data = '0;

    spi_arb #(
        .GAP_CYC (GAP_CYC),
        .TMO_CYC (TMO_CYC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .wt_data0    (wt_data0),
        .req1        (req1),
        .wt_data1    (wt_data1),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rd_data     (rd_data),
        .busy        (busy),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state
    int          m_last;      // index served last
    logic [15:0] m_rd;        // expected rd_data
    int          m_prev_wrt;
    bit          m_have_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_winner(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    // Called when ISSUE is visible. Runs the frame through to IDLE.
    //   nb        : BUSY cycles before spi_done (ignored on timeout)
    //   give_done : spi_done arrives; otherwise the watchdog fires
    //   drop      : requests dropped right after ISSUE
    //   gap_pulse : requester 1 pulses one cycle during GAP
    task automatic frame(input int who, input logic [15:0] cmd, input int nb,
                         input bit give_done, input bit drop, input bit gap_pulse);
        logic [1:0]  oh;
        logic [15:0] rdv;
        bit          quiet;
        int          n;
        oh = (who == 1) ? 2'b10 : 2'b01;
        chk("issue_wrt",  32'(spi_wrt), 1);
        chk("issue_gnt",  32'(gnt), 32'(oh));
        chk("issue_cmd",  32'(spi_cmd), 32'(cmd));
        chk("issue_busy", 32'(busy), 1);
        if (m_have_prev) chk("wrt_spacing", 32'((cyc - m_prev_wrt) >= GAP_CYC + 2), 1);
        m_prev_wrt  = cyc;
        m_have_prev = 1'b1;
        // Command inputs change after sampling; spi_cmd must not follow
        wt_data0 = 16'($urandom);
        wt_data1 = 16'($urandom);
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        n = give_done ? nb : TMO_CYC;
        quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (spi_wrt !== 1'b0 || done !== 2'b00 || err !== 2'b00 ||
                gnt !== oh || spi_cmd !== cmd || busy !== 1'b1) quiet = 1'b0;
        end
        chk("busy_quiet", 32'(quiet), 1);
        rdv         = 16'($urandom);
        spi_rd_data = rdv;
        spi_done    = give_done;
        tick();
        spi_done    = 1'b0;
        spi_rd_data = 16'($urandom);
        if (give_done) m_rd = rdv;
        chk("end_done", 32'(done), give_done ? 32'(oh) : 0);
        chk("end_err",  32'(err),  give_done ? 0 : 32'(oh));
        chk("end_rd",   32'(rd_data), 32'(m_rd));
        chk("end_gnt",  32'(gnt), 32'(oh));
        m_last = who;
        if (gap_pulse) req1 = 1'b1;
        tick();
        req1 = gap_pulse ? 1'b0 : req1;
        chk("gap_gnt",   32'(gnt), 0);
        chk("gap_pulse", 32'({done, err}), 0);
        quiet = 1'b1;
        for (int i = 0; i < GAP_CYC - 2; i++) begin
            tick();
            if (busy !== 1'b1 || spi_wrt !== 1'b0 || gnt !== 2'b00) quiet = 1'b0;
        end
        chk("gap_hold", 32'(quiet), 1);
        tick();
        chk("idle_busy", 32'(busy), 0);
    endtask

    // Present requests while IDLE is visible, then run the resulting frame.
    task automatic go(input bit r0, input bit r1, input int nb, input bit give_done,
                      input bit drop, input bit gap_pulse);
        int          w;
        logic [15:0] cmd;
        wt_data0 = 16'($urandom);
        wt_data1 = 16'($urandom);
        req0 = r0;
        req1 = r1;
        w   = rr_winner(r0, r1, m_last);
        cmd = (w == 1) ? wt_data1 : wt_data0;
        tick();
        frame(w, cmd, nb, give_done, drop, gap_pulse);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_rd"},   32'(rd_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wrt"},  32'(spi_wrt), 0);
        chk({tag, "_cmd"},  32'(spi_cmd), 0);
    endtask

    initial begin
        bit          quiet;
        bit          r0;
        bit          r1;
        m_last      = 1;
        m_rd        = '0;
        m_have_prev = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("rst");

        // Single request with the documented command
        wt_data0 = 16'hA200;
        req0     = 1'b1;
        tick();
        frame(0, 16'hA200, 40, 1'b1, 1'b0, 1'b0);
        req0 = 1'b0;

        // Contention: both held for four frames -> 0,1,0,1 alternation
        // (requester 0 was served last, so the first tie goes to 1 here;
        // the alternation property is what is checked)
        for (int k = 0; k < 4; k++) go(1'b1, 1'b1, $urandom_range(1, 20), 1'b1, 1'b0, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;

        // Timeout on requester 1
        wt_data1 = 16'h1150;
        req1     = 1'b1;
        tick();
        frame(1, 16'h1150, 0, 1'b0, 1'b0, 1'b0);
        req1 = 1'b0;

        // Race: spi_done on the watchdog's last BUSY cycle
        go(1'b1, 1'b0, TMO_CYC, 1'b1, 1'b0, 1'b0);

        // Withdrawal: req1 pulsed during GAP is never granted
        go(1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b1);
        req0 = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (spi_wrt !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00) quiet = 1'b0;
        end
        chk("gap_req_ignored", 32'(quiet), 1);

        // req0 dropped right after ISSUE still completes
        go(1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b0);

        // Stray spi_done in IDLE is ignored
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        chk("idle_stray_done", 32'({done, busy}), 0);

        // Randomised mix of request patterns, lengths and timeouts
        for (int k = 0; k < 8; k++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            go(r0, r1, $urandom_range(1, 30), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset in the middle of BUSY
        wt_data0 = 16'h5A5A;
        req0     = 1'b1;
        tick();
        chk("pre_rst_wrt", 32'(spi_wrt), 1);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        req0 = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        m_last      = 1;
        m_rd        = '0;
        m_have_prev = 1'b0;
        spi_done    = 1'b1;
        tick();
        spi_done    = 1'b0;
        tick();
        chk("post_rst_stray", 32'({done, err, busy}), 0);

        // Pointer is back to its reset value: a tie goes to requester 0
        go(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        req1 = 1'b0;
        go(1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        req0 = 1'b0;

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_spi_arb
`default_nettype wire
